// File: rtl/memi_loader.sv
// Instruction-memory loader: byte stream -> big-endian 32-bit word writes from BASE_ADDR upward; 5+ cycles per word.
// Backpressure: o_in_ready is registered and high only in RECV/CHECK. Optional trailer checksum via LOADER_CHECKSUM_EN.
module memi_loader #(
    parameter logic [31:0] BASE_ADDR = 32'd0,
    parameter int          MAX_WORDS = 64,
    parameter int          CNT_W     = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_word_count,
    input  logic [7:0]       i_in_byte,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    output logic             o_wr_en,
    output logic [31:0]      o_wr_addr,
    output logic [31:0]      o_wr_data,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_DONE,
        S_CHECK
    } state_t;

    localparam logic [CNT_W-1:0] MAX_W = CNT_W'(MAX_WORDS);

    state_t           r_state;
    logic [31:0]      r_word;
    logic [1:0]       r_idx;
    logic [31:0]      r_addr;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_count;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0]      r_xor;
`endif

    logic [31:0]      w_word_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_oversize;

    assign w_word_next = {r_word[23:0], i_in_byte};
    assign w_cnt_next  = r_cnt + CNT_W'(1);
    assign w_oversize  = (i_word_count > MAX_W);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_word     <= 32'd0;
            r_idx      <= 2'd0;
            r_addr     <= BASE_ADDR;
            r_cnt      <= '0;
            r_count    <= '0;
`ifdef LOADER_CHECKSUM_EN
            r_xor      <= 32'd0;
`endif
            o_in_ready <= 1'b0;
            o_wr_en    <= 1'b0;
            o_wr_addr  <= BASE_ADDR;
            o_wr_data  <= 32'd0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    o_done <= 1'b0;
                    if (i_start) begin
                        if (w_oversize) begin
                            // Rejected request: report and stay idle without touching memory.
                            o_err  <= 1'b1;
                            o_done <= 1'b1;
                        end else begin
                            o_err   <= 1'b0;
                            o_busy  <= 1'b1;
                            r_count <= i_word_count;
                            r_addr  <= BASE_ADDR;
                            r_idx   <= 2'd0;
                            r_cnt   <= '0;
`ifdef LOADER_CHECKSUM_EN
                            r_xor   <= 32'd0;
`endif
                            if (i_word_count == '0) begin
`ifdef LOADER_CHECKSUM_EN
                                r_state    <= S_CHECK;
                                o_in_ready <= 1'b1;
`else
                                r_state    <= S_DONE;
                                o_done     <= 1'b1;
`endif
                            end else begin
                                r_state    <= S_RECV;
                                o_in_ready <= 1'b1;
                            end
                        end
                    end
                end
                S_RECV: begin
                    if (i_in_valid && o_in_ready) begin
                        r_word <= w_word_next;
                        r_idx  <= r_idx + 2'd1;
                        if (r_idx == 2'd3) begin
                            o_in_ready <= 1'b0;
                            o_wr_en    <= 1'b1;
                            o_wr_addr  <= r_addr;
                            o_wr_data  <= w_word_next;
                            r_state    <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    o_wr_en <= 1'b0;
                    r_addr  <= r_addr + 32'd4;
                    r_cnt   <= w_cnt_next;
`ifdef LOADER_CHECKSUM_EN
                    r_xor   <= r_xor ^ o_wr_data;
`endif
                    if (w_cnt_next == r_count) begin
`ifdef LOADER_CHECKSUM_EN
                        r_state    <= S_CHECK;
                        o_in_ready <= 1'b1;
`else
                        r_state    <= S_DONE;
                        o_done     <= 1'b1;
`endif
                    end else begin
                        r_state    <= S_RECV;
                        o_in_ready <= 1'b1;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CHECK: begin
                    // The byte index has wrapped to 0 after the last word, so the trailer reuses it.
                    if (i_in_valid && o_in_ready) begin
                        r_word <= w_word_next;
                        r_idx  <= r_idx + 2'd1;
                        if (r_idx == 2'd3) begin
                            o_in_ready <= 1'b0;
                            o_err      <= (w_word_next != r_xor);
                            o_done     <= 1'b1;
                            r_state    <= S_DONE;
                        end
                    end
                end
`endif
                S_DONE: begin
                    o_done  <= 1'b0;
                    o_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memi_loader.sv
// Directed self-checking bench for memi_loader; two instances (BASE_ADDR 0 and 100) share stimulus.
module tb_memi_loader;

    logic        clk;
    logic        i_rst;
    logic        i_start;
    logic [15:0] i_word_count;
    logic [7:0]  i_in_byte;
    logic        i_in_valid;

    logic        o_in_ready0, o_wr_en0, o_busy0, o_done0, o_err0;
    logic [31:0] o_wr_addr0, o_wr_data0;
    logic        o_in_ready1, o_wr_en1, o_busy1, o_done1, o_err1;
    logic [31:0] o_wr_addr1, o_wr_data1;

    int errors = 0;
    int checks = 0;
    int wr_cnt0 = 0;
    int wr_cnt1 = 0;
    logic [31:0] mem0 [0:63];

    memi_loader #(.BASE_ADDR(32'd0), .MAX_WORDS(64), .CNT_W(16)) dut0 (
        .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_word_count(i_word_count),
        .i_in_byte(i_in_byte), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready0),
        .o_wr_en(o_wr_en0), .o_wr_addr(o_wr_addr0), .o_wr_data(o_wr_data0),
        .o_busy(o_busy0), .o_done(o_done0), .o_err(o_err0)
    );

    memi_loader #(.BASE_ADDR(32'd100), .MAX_WORDS(64), .CNT_W(16)) dut1 (
        .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_word_count(i_word_count),
        .i_in_byte(i_in_byte), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready1),
        .o_wr_en(o_wr_en1), .o_wr_addr(o_wr_addr1), .o_wr_data(o_wr_data1),
        .o_busy(o_busy1), .o_done(o_done1), .o_err(o_err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory model behind dut0, plus write counters for both instances.
    always @(negedge clk) begin
        if (o_wr_en0) begin
            wr_cnt0 = wr_cnt0 + 1;
            mem0[o_wr_addr0[7:2]] = o_wr_data0;
        end
        if (o_wr_en1) wr_cnt1 = wr_cnt1 + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int n;
        n = 0;
        i_in_byte  = b;
        i_in_valid = 1'b1;
        while (o_in_ready0 !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) begin
            checks++; errors++;
            $display("FAIL in_ready_timeout got=%b want=1", o_in_ready0);
        end
        tick();
        if (gap) begin
            i_in_valid = 1'b0;
            tick();
        end
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8], gap && (i < 3));
    endtask

    // From the WRITE cycle of the last word, reach the DONE cycle.
    task automatic finish_load(input logic [31:0] trailer);
`ifdef LOADER_CHECKSUM_EN
        send_word(trailer, 1'b0);
        i_in_valid = 1'b0;
`else
        tick();
`endif
    endtask

    task automatic start_load(input logic [15:0] wc);
        i_start = 1'b1;
        i_word_count = wc;
        tick();
        i_start = 1'b0;
    endtask

    task automatic pulse_reset;
        @(negedge clk);
        i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        i_rst = 1'b1;
        #12;
        checks++; if (o_in_ready0 !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%b want=0", o_in_ready0); end
        checks++; if (o_wr_en0 !== 1'b0) begin errors++; $display("FAIL rst_wr_en got=%b want=0", o_wr_en0); end
        checks++; if (o_wr_addr0 !== 32'd0) begin errors++; $display("FAIL rst_wr_addr0 got=%h want=0", o_wr_addr0); end
        checks++; if (o_wr_addr1 !== 32'd100) begin errors++; $display("FAIL rst_wr_addr1 got=%h want=64", o_wr_addr1); end
        checks++; if (o_wr_data0 !== 32'd0) begin errors++; $display("FAIL rst_wr_data got=%h want=0", o_wr_data0); end
        checks++; if ({o_busy0, o_done0, o_err0} !== 3'b000) begin errors++; $display("FAIL rst_bde got=%b want=000", {o_busy0, o_done0, o_err0}); end
        @(negedge clk);
        i_rst = 1'b0;
        tick();
    endtask

    task automatic test_basic;
        int w0;
        w0 = wr_cnt0;
        start_load(16'd2);
        checks++; if (o_busy0 !== 1'b1) begin errors++; $display("FAIL basic_busy got=%b want=1", o_busy0); end
        send_word(32'h20080005, 1'b0);
        checks++; if (o_wr_en0 !== 1'b1 || o_wr_addr0 !== 32'd0 || o_wr_data0 !== 32'h20080005)
            begin errors++; $display("FAIL basic_w0 got=%b/%h/%h want=1/0/20080005", o_wr_en0, o_wr_addr0, o_wr_data0); end
        send_word(32'h8C090004, 1'b0);
        checks++; if (o_wr_en0 !== 1'b1 || o_wr_addr0 !== 32'd4 || o_wr_data0 !== 32'h8C090004)
            begin errors++; $display("FAIL basic_w1 got=%b/%h/%h want=1/4/8c090004", o_wr_en0, o_wr_addr0, o_wr_data0); end
        finish_load(32'hAC010001);
        checks++; if ({o_done0, o_busy0, o_err0} !== 3'b110) begin errors++; $display("FAIL basic_done got=%b want=110", {o_done0, o_busy0, o_err0}); end
        tick();
        checks++; if ({o_done0, o_busy0} !== 2'b00) begin errors++; $display("FAIL basic_idle got=%b want=00", {o_done0, o_busy0}); end
        checks++; if (o_wr_en0 !== 1'b0 || o_wr_addr0 !== 32'd4 || o_wr_data0 !== 32'h8C090004)
            begin errors++; $display("FAIL basic_hold got=%b/%h/%h want=0/4/8c090004", o_wr_en0, o_wr_addr0, o_wr_data0); end
        checks++; if (mem0[0] !== 32'h20080005 || mem0[1] !== 32'h8C090004)
            begin errors++; $display("FAIL basic_mem got=%h/%h want=20080005/8c090004", mem0[0], mem0[1]); end
        checks++; if (wr_cnt0 - w0 !== 2) begin errors++; $display("FAIL basic_wcnt got=%0d want=2", wr_cnt0 - w0); end
    endtask

    task automatic test_base100_toggle;
        int w1;
        w1 = wr_cnt1;
        start_load(16'd1);
        send_word(32'hAABBCCDD, 1'b1);
        checks++; if (o_wr_en1 !== 1'b1 || o_wr_addr1 !== 32'd100 || o_wr_data1 !== 32'hAABBCCDD)
            begin errors++; $display("FAIL b100_write got=%b/%h/%h want=1/64/aabbccdd", o_wr_en1, o_wr_addr1, o_wr_data1); end
        checks++; if (o_in_ready1 !== 1'b0) begin errors++; $display("FAIL b100_ready got=%b want=0", o_in_ready1); end
        finish_load(32'hAABBCCDD);
        checks++; if (o_done1 !== 1'b1 || o_err1 !== 1'b0) begin errors++; $display("FAIL b100_done got=%b%b want=10", o_done1, o_err1); end
        tick();
        checks++; if (wr_cnt1 - w1 !== 1) begin errors++; $display("FAIL b100_wcnt got=%0d want=1", wr_cnt1 - w1); end
    endtask

    task automatic test_oversize;
        int w0;
        w0 = wr_cnt0;
        start_load(16'd65);
        checks++; if ({o_err0, o_done0, o_busy0, o_in_ready0} !== 4'b1100)
            begin errors++; $display("FAIL over_pulse got=%b want=1100", {o_err0, o_done0, o_busy0, o_in_ready0}); end
        tick();
        checks++; if ({o_err0, o_done0, o_busy0} !== 3'b100) begin errors++; $display("FAIL over_sticky got=%b want=100", {o_err0, o_done0, o_busy0}); end
        checks++; if (wr_cnt0 - w0 !== 0) begin errors++; $display("FAIL over_wcnt got=%0d want=0", wr_cnt0 - w0); end
        start_load(16'd64);
        checks++; if ({o_err0, o_busy0, o_in_ready0} !== 3'b011)
            begin errors++; $display("FAIL max_accept got=%b want=011", {o_err0, o_busy0, o_in_ready0}); end
        pulse_reset();
    endtask

    task automatic test_zero_count;
        int w0;
        w0 = wr_cnt0;
        start_load(16'd0);
`ifdef LOADER_CHECKSUM_EN
        send_word(32'd0, 1'b0);
        i_in_valid = 1'b0;
`endif
        checks++; if ({o_done0, o_busy0, o_err0} !== 3'b110) begin errors++; $display("FAIL zero_done got=%b want=110", {o_done0, o_busy0, o_err0}); end
        tick();
        checks++; if (o_busy0 !== 1'b0 || wr_cnt0 - w0 !== 0) begin errors++; $display("FAIL zero_end got=%b/%0d want=0/0", o_busy0, wr_cnt0 - w0); end
    endtask

    task automatic test_reset_midload;
        int w0;
        w0 = wr_cnt0;
        start_load(16'd3);
        send_word(32'hCAFEF00D, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        i_in_valid = 1'b0;
        @(negedge clk);
        i_rst = 1'b1;
        #1;
        checks++; if ({o_in_ready0, o_wr_en0, o_busy0, o_done0, o_err0} !== 5'b00000 || o_wr_data0 !== 32'd0 || o_wr_addr0 !== 32'd0)
            begin errors++; $display("FAIL mid_rst got=%b/%h/%h want=00000/0/0", {o_in_ready0, o_wr_en0, o_busy0, o_done0, o_err0}, o_wr_data0, o_wr_addr0); end
        @(negedge clk);
        i_rst = 1'b0;
        tick();
        start_load(16'd1);
        send_word(32'h12345678, 1'b0);
        checks++; if (o_wr_en0 !== 1'b1 || o_wr_addr0 !== 32'd0 || o_wr_data0 !== 32'h12345678)
            begin errors++; $display("FAIL mid_reload got=%b/%h/%h want=1/0/12345678", o_wr_en0, o_wr_addr0, o_wr_data0); end
        finish_load(32'h12345678);
        tick();
        checks++; if (mem0[0] !== 32'h12345678 || wr_cnt0 - w0 !== 2)
            begin errors++; $display("FAIL mid_mem got=%h/%0d want=12345678/2", mem0[0], wr_cnt0 - w0); end
    endtask

    task automatic test_start_ignored;
        int w0;
        w0 = wr_cnt0;
        start_load(16'd2);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        i_start = 1'b1;
        i_word_count = 16'd5;
        send_byte(8'h33, 1'b0);
        i_start = 1'b0;
        send_byte(8'h44, 1'b0);
        send_word(32'h55667788, 1'b0);
        checks++; if (o_wr_addr0 !== 32'd4 || o_wr_data0 !== 32'h55667788)
            begin errors++; $display("FAIL ign_w1 got=%h/%h want=4/55667788", o_wr_addr0, o_wr_data0); end
        finish_load(32'h444444CC);
        checks++; if (o_done0 !== 1'b1 || o_err0 !== 1'b0) begin errors++; $display("FAIL ign_done got=%b%b want=10", o_done0, o_err0); end
        tick();
        checks++; if (wr_cnt0 - w0 !== 2 || mem0[0] !== 32'h11223344)
            begin errors++; $display("FAIL ign_count got=%0d/%h want=2/11223344", wr_cnt0 - w0, mem0[0]); end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum;
        int w0;
        w0 = wr_cnt0;
        start_load(16'd2);
        send_word(32'h00000001, 1'b0);
        send_word(32'h00000003, 1'b0);
        send_word(32'h00000002, 1'b0);
        i_in_valid = 1'b0;
        checks++; if (o_done0 !== 1'b1 || o_err0 !== 1'b0) begin errors++; $display("FAIL csum_ok got=%b%b want=10", o_done0, o_err0); end
        tick();
        start_load(16'd2);
        send_word(32'h00000001, 1'b0);
        send_word(32'h00000003, 1'b0);
        send_word(32'h00000007, 1'b0);
        i_in_valid = 1'b0;
        checks++; if (o_done0 !== 1'b1 || o_err0 !== 1'b1) begin errors++; $display("FAIL csum_bad got=%b%b want=11", o_done0, o_err0); end
        tick();
        checks++; if (wr_cnt0 - w0 !== 4 || o_err0 !== 1'b1) begin errors++; $display("FAIL csum_writes got=%0d/%b want=4/1", wr_cnt0 - w0, o_err0); end
    endtask
`endif

    initial begin
        i_rst = 1'b1;
        i_start = 1'b0;
        i_word_count = 16'd0;
        i_in_byte = 8'd0;
        i_in_valid = 1'b0;
        test_reset();
        test_basic();
        test_base100_toggle();
        test_oversize();
        test_zero_count();
        test_reset_midload();
        test_start_ignored();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/memi_loader.md
# memi_loader

Instruction-memory loader: the write side of the instruction memory (MEMI), which the fetch path reads combinationally by byte address. It accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and issues one-cycle word writes at consecutive word-aligned byte addresses starting at `BASE_ADDR`. It sits between the host/boot byte source and the instruction memory's write port and is active only before the processor is released from reset.

## Interface
- `BASE_ADDR`, 32'd0: byte address of the first word written; must be a multiple of 4.
- `MAX_WORDS`, 64: instruction memory depth in words; a larger load request is rejected.
- `CNT_W`, 16: width of the `word_count` port and the internal word counter.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  level sampled in IDLE; begins a load.
- `word_count`  in  CNT_W  number of words to load; sampled when `start` is accepted.
- `in_byte`  in  8  stream byte.
- `in_valid`  in  1  `in_byte` is valid.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `wr_en`  out  1  memory write strobe, one cycle per word.
- `wr_addr`  out  32  byte address of the word; always a multiple of 4.
- `wr_data`  out  32  instruction word; the first received byte is bits [31:24].
- `busy`  out  1  high from `start` acceptance until DONE is left.
- `done`  out  1  one-cycle pulse at the end of the load.
- `err`  out  1  sticky error; cleared on the next accepted `start` or on reset.

## Operation
- States: IDLE, RECV, WRITE, DONE. With `LOADER_CHECKSUM_EN` defined, the CHECK state is added.
- IDLE: `in_ready`=0.
  - If `start`=1 and `word_count` > `MAX_WORDS`: set `err`, pulse `done`, stay IDLE with no writes.
  - If `start`=1 and `word_count`=0: go to DONE (or CHECK when checksum is enabled).
  - If `start`=1 otherwise: latch the count, clear `err`, set address to `BASE_ADDR`, clear the byte index, go to RECV.
- RECV: `in_ready`=1.
  - A byte is accepted on a clock edge with `in_valid && in_ready`.
  - Accepted bytes shift into the word register MSB-first; the byte index is 2 bits.
  - Acceptance of the 4th byte moves the block to WRITE.
  - `in_valid` low stalls indefinitely; there is no timeout.
- WRITE: `in_ready`=0 and `wr_en`=1 for exactly one cycle, with `wr_addr`/`wr_data` stable.
  - Next edge: address += 4 (32-bit, wraps modulo 2^32) and written-word count += 1.
  - If count == latched `word_count`, go to DONE (or CHECK); otherwise go to RECV.
- DONE: `done`=1 for one cycle, `busy`=0 next cycle, return to IDLE.
- `start` asserted outside IDLE is ignored.
- `wr_addr`/`wr_data` hold their last values when `wr_en`=0.

## Timing
- Reset values:
  - state IDLE
  - `in_ready`=0, `wr_en`=0, `wr_addr`=`BASE_ADDR`, `wr_data`=0
  - `busy`=0, `done`=0, `err`=0
- `busy` rises in the cycle after `start` is accepted in IDLE.
- `wr_en` is asserted in the cycle immediately following the 4th byte handshake.
- Minimum 5 cycles per word: 4 accept cycles plus 1 WRITE cycle.
- `done` is asserted in the cycle after the last WRITE (or the last CHECK cycle).
- Reset mid-load aborts immediately. Words already written remain in memory; a partially assembled word is discarded.
- All outputs are registered; there is no combinational path from `in_valid` to `in_ready`.

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - After the last data word, CHECK accepts 4 more bytes as a big-endian checksum word, with `in_ready`=1.
  - The checksum is compared with the XOR of all data words written in this load; the XOR is 0 when `word_count`=0.
  - Mismatch sets `err`. DONE follows in either case.
  - The checksum word is never written to memory.
- Undefined: no CHECK state and no trailer bytes. `err` is set only by the oversize request.

## Test plan
- Reset, then `start`, `word_count`=2, bytes 20 08 00 05 8C 09 00 04 with `in_valid` held high -> first WRITE addr 0 data 32'h20080005, second WRITE addr 4 data 32'h8C090004, `done` pulse, `err`=0; reading the instruction memory at DR=0 and DR=4 returns the same words.
- `BASE_ADDR`=100, one word AABBCCDD with `in_valid` toggling every other cycle -> single `wr_en` at addr 100, data 32'hAABBCCDD, `in_ready` low during WRITE.
- `word_count`=65 with `MAX_WORDS`=64 -> `err`=1, `done` pulse, no `wr_en`, `busy` stays 0.
- `word_count`=3, assert `rst` after byte 6 -> all outputs return to reset values at once; a new load of 1 word then writes addr 0 correctly.
- Checksum enabled, words 00000001 and 00000003 with trailer 00000002 -> `err`=0. Repeat with trailer 00000007 -> `err`=1, `done` pulse, and no third write.
- `start` pulsed during RECV -> ignored; the load completes with the original count.
